uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  Parametrised UART receiver: the successor to the fixed 8N1 receiver.
//  - Configurable data width, parity mode and stop-bit count.
//  - Reports parity, framing and line-break errors alongside each word.
//  - Sits between an async rx pin and the byte/command parsers; one word per valid_o pulse.
// PARAMETERS
//  CLOCKS_PER_BAUD  6  clock cycles per bit; must be >=2 (>=4 when UART_RX_MAJORITY_EN is defined)
//  DATA_BITS        8  data bits per frame, 5..9, LSB first
//  PARITY           0  parity mode: 0 none, 1 odd, 2 even
//  STOP_BITS        1  stop bits checked, 1 or 2
// PORTS
//  clock         in   1          system clock; all logic on rising edge
//  reset_n       in   1          asynchronous, active-low reset
//  rx_i          in   1          async serial line, idle high
//  data_o        out  DATA_BITS  last received word; held until next valid_o
//  valid_o       out  1          one-cycle pulse: new word on data_o plus error flags
//  parity_err_o  out  1          parity mismatch for this word; qualified by valid_o
//  frame_err_o   out  1          a stop bit sampled low; qualified by valid_o
//  break_o       out  1          all data bits, parity and stop sampled low; qualified by valid_o
//  tap_o         out  1          high whenever the FSM is not IDLE (debug)
// BEHAVIOUR
//  Reset
//   - 2FF synchronizer flops reset to 1; FSM resets to IDLE; counters reset to 0.
//   - All outputs reset to 0, including data_o.
//   - reset_n low mid-frame aborts the frame; no valid_o for the partial word.
//  Sampling
//   - rx = synchronizer output (2 cycles of input latency).
//   - baud counter width is $clog2(CLOCKS_PER_BAUD); it counts down.
//   - Sample point is the cycle the counter reaches 0.
//  FSM states and transitions
//   - IDLE: rx==0 -> START, counter=CLOCKS_PER_BAUD/2-1.
//   - START: at sample, rx==1 -> IDLE (false start, no output); else -> DATA, counter=CLOCKS_PER_BAUD-1.
//   - DATA: DATA_BITS samples shifted in LSB-first. Then -> PARITY if PARITY!=0, else -> STOP.
//   - PARITY: one sample. Odd mode: error if XOR(data, bit) == 0. Even mode: error if it == 1.
//   - STOP: STOP_BITS samples; any low sample sets frame error. After the last sample:
//     - data_o and flags are registered; valid_o pulses in the next cycle.
//     - If break was detected -> BREAK_WAIT; else -> IDLE.
//   - BREAK_WAIT: stay until rx==1, then -> IDLE. Line-low here never starts a frame.
//  Timing and flags
//   - Latency from the synced falling edge to valid_o:
//     CLOCKS_PER_BAUD/2 + (DATA_BITS + (PARITY!=0) + STOP_BITS)*CLOCKS_PER_BAUD + 1 cycles.
//   - Flags are meaningful only while valid_o=1.
//   - A word with errors is still presented on data_o with valid_o.
//   - break_o implies frame_err_o.
//   - IDLE re-arms the cycle after the last stop sample, so back-to-back frames need no extra gap.
//   - Illegal parameter values must be rejected with $error at elaboration.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//   - Each sample (start, data, parity, stop) is the 2-of-3 majority of rx over the three
//     cycles ending at the sample point.
//   - A 1-cycle glitch at the centre is rejected; latency is unchanged.
//  UART_RX_MAJORITY_EN undefined:
//   - Single sample of rx at the sample point; no vote logic is generated.
// TESTING
//  (CLOCKS_PER_BAUD=6 unless stated)
//  1. 8N1, send 0xA5 with correct stop -> data_o=0xA5, valid_o high exactly 1 cycle, all error flags 0.
//  2. rx_i low for 2 cycles then high -> FSM returns to IDLE, no valid_o.
//  3. PARITY=2, DATA_BITS=7: send 0x01 with parity bit 0 -> parity_err_o=1; with bit 1 -> 0.
//  4. STOP_BITS=2: send 0x3C, second stop bit low -> valid_o, data_o=0x3C, frame_err_o=1, break_o=0.
//  5. Line held low for 12 bit times, then high, then 0x55 ->
//     - first: valid_o with data_o=0, break_o=1, frame_err_o=1, no further words while low;
//     - then: 0x55 received cleanly after the line returns high.
//  6. reset_n pulsed low mid data bit 4 -> outputs 0 immediately; next full frame 0x81 received correctly.
//     With UART_RX_MAJORITY_EN: 1-cycle high glitch on a 0 data bit at its centre -> bit still reads 0.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable data bits, parity and stop bits, with parity,
// framing and line-break flags. Define UART_RX_MAJORITY_EN for 2-of-3 voted sampling.
module uart_rx_frame #(
    parameter int CLOCKS_PER_BAUD = 6,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 tap_o
);

    localparam int CW = (CLOCKS_PER_BAUD > 2) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam bit PAR_EN = (PARITY != 0);

    generate
        if (CLOCKS_PER_BAUD < 2) begin : g_bad_cpb
            $error("uart_rx_frame: CLOCKS_PER_BAUD must be >= 2");
        end
`ifdef UART_RX_MAJORITY_EN
        if (CLOCKS_PER_BAUD < 4) begin : g_bad_cpb_vote
            $error("uart_rx_frame: CLOCKS_PER_BAUD must be >= 4 with majority voting");
        end
`endif
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_rx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   samp;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_acc;
    logic                   any_high;
    logic                   frame_acc;
    logic                   frame_now;
    logic                   brk_now;
    logic                   par_err_w;

    // Two-flop synchronizer; idle level is high so reset to 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1;
    logic rx_d2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_sync;
            rx_d2 <= rx_d1;
        end
    end

    // Vote over the sample cycle and the two cycles before it.
    assign samp = (rx_sync & rx_d1) | (rx_sync & rx_d2) | (rx_d1 & rx_d2);
`else
    assign samp = rx_sync;
`endif

    assign frame_now = frame_acc | ~samp;
    assign brk_now   = ~(any_high | samp);

    always_comb begin
        par_err_w = 1'b0;
        if (PARITY == 1) begin
            par_err_w = ~par_acc;
        end else if (PARITY == 2) begin
            par_err_w = par_acc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            par_acc      <= 1'b0;
            any_high     <= 1'b0;
            frame_acc    <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            tap_o        <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (state != IDLE && state != BREAK_WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        tap_o <= 1'b1;
                        cnt   <= CW'(CLOCKS_PER_BAUD / 2 - 1);
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (samp) begin
                            state <= IDLE;
                            tap_o <= 1'b0;
                        end else begin
                            state     <= DATA;
                            cnt       <= CW'(CLOCKS_PER_BAUD - 1);
                            bit_cnt   <= '0;
                            par_acc   <= 1'b0;
                            any_high  <= 1'b0;
                            frame_acc <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt      <= CW'(CLOCKS_PER_BAUD - 1);
                        shift    <= {samp, shift[DATA_BITS-1:1]};
                        par_acc  <= par_acc ^ samp;
                        any_high <= any_high | samp;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= PAR_EN ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                PAR: begin
                    if (cnt == '0) begin
                        cnt      <= CW'(CLOCKS_PER_BAUD - 1);
                        par_acc  <= par_acc ^ samp;
                        any_high <= any_high | samp;
                        bit_cnt  <= '0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        cnt <= CW'(CLOCKS_PER_BAUD - 1);
                        if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            data_o       <= shift;
                            valid_o      <= 1'b1;
                            parity_err_o <= par_err_w;
                            frame_err_o  <= frame_now;
                            break_o      <= brk_now;
                            bit_cnt      <= '0;
                            state        <= brk_now ? BREAK_WAIT : IDLE;
                            tap_o        <= brk_now;
                        end else begin
                            frame_acc <= frame_now;
                            any_high  <= any_high | samp;
                            bit_cnt   <= bit_cnt + BW'(1);
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (rx_sync) begin
                        state <= IDLE;
                        tap_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tap_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: three configurations (8N1, 7E1, 8N2) on separate lines.
module tb_uart_rx_frame;

    localparam int CPB = 6;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic clock;
    logic reset_n;
    logic line;
    int   sel;
    int   checks;
    int   errors;

    logic rx_a, rx_p, rx_s;
    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_p = (sel == 1) ? line : 1'b1;
    assign rx_s = (sel == 2) ? line : 1'b1;

    logic [7:0] data_a;
    logic       valid_a, pe_a, fe_a, bk_a, tap_a;
    logic [6:0] data_p;
    logic       valid_p, pe_p, fe_p, bk_p, tap_p;
    logic [7:0] data_s;
    logic       valid_s, pe_s, fe_s, bk_s, tap_s;

    exp_t q_a[$];
    exp_t q_p[$];
    exp_t q_s[$];
    exp_t ea, ep, es;

    uart_rx_frame #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a),
        .parity_err_o(pe_a), .frame_err_o(fe_a), .break_o(bk_a), .tap_o(tap_a));

    uart_rx_frame #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_p (
        .clock(clock), .reset_n(reset_n), .rx_i(rx_p), .data_o(data_p), .valid_o(valid_p),
        .parity_err_o(pe_p), .frame_err_o(fe_p), .break_o(bk_p), .tap_o(tap_p));

    uart_rx_frame #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_s (
        .clock(clock), .reset_n(reset_n), .rx_i(rx_s), .data_o(data_s), .valid_o(valid_s),
        .parity_err_o(pe_s), .frame_err_o(fe_s), .break_o(bk_s), .tap_o(tap_s));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", nm, got, want);
        end
    endtask

    task automatic check_word(input string tag, input exp_t e, input logic [8:0] d,
                              input logic pe, input logic fe, input logic bk);
        cmp({tag, "_data"}, int'(d), int'(e.d));
        cmp({tag, "_parity_err"}, int'(pe), int'(e.pe));
        cmp({tag, "_frame_err"}, int'(fe), int'(e.fe));
        cmp({tag, "_break"}, int'(bk), int'(e.bk));
    endtask

    task automatic unexpected(input string tag, input int d);
        checks++;
        errors++;
        $display("FAIL %s_unexpected_word got=%0h required=none", tag, d);
    endtask

    // Monitors: pop and compare whenever a receiver presents a word.
    always @(negedge clock) begin
        if (reset_n && valid_a) begin
            if (q_a.size() == 0) unexpected("a", int'(data_a));
            else begin
                ea = q_a.pop_front();
                check_word("a", ea, {1'b0, data_a}, pe_a, fe_a, bk_a);
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && valid_p) begin
            if (q_p.size() == 0) unexpected("p", int'(data_p));
            else begin
                ep = q_p.pop_front();
                check_word("p", ep, {2'b0, data_p}, pe_p, fe_p, bk_p);
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && valid_s) begin
            if (q_s.size() == 0) unexpected("s", int'(data_s));
            else begin
                es = q_s.pop_front();
                check_word("s", es, {1'b0, data_s}, pe_s, fe_s, bk_s);
            end
        end
    end

    task automatic push(input int which, input logic [8:0] d, input logic pe,
                        input logic fe, input logic bk);
        exp_t e;
        e = '{d: d, pe: pe, fe: fe, bk: bk};
        case (which)
            0: q_a.push_back(e);
            1: q_p.push_back(e);
            default: q_s.push_back(e);
        endcase
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        line = v;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input int has_par,
                              input logic pbit, input logic s1, input logic s2, input int ns);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (has_par != 0) drive_bit(pbit);
        drive_bit(s1);
        if (ns == 2) drive_bit(s2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        line    = 1'b1;
        sel     = 0;
        reset_n = 1'b0;
        wait_cycles(4);
        cmp("reset_data", int'(data_a), 0);
        cmp("reset_valid", int'(valid_a), 0);
        cmp("reset_flags", int'({pe_a, fe_a, bk_a}), 0);
        cmp("reset_tap", int'(tap_a), 0);
        reset_n = 1'b1;
        wait_cycles(4);

        // 8N1 clean word
        push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive_bit(1'b1);

        // Short low pulse is a false start
        line = 1'b0;
        wait_cycles(2);
        line = 1'b1;
        wait_cycles(10);
        cmp("false_start_tap", int'(tap_a), 0);

        // 7E1: parity bit 0 on 0x01 is wrong, 1 is right; 0x7F with 1 is right
        sel = 1;
        wait_cycles(2);
        push(1, 9'h001, 1'b1, 1'b0, 1'b0);
        send_frame(9'h001, 7, 1, 1'b0, 1'b1, 1'b1, 1);
        push(1, 9'h001, 1'b0, 1'b0, 1'b0);
        send_frame(9'h001, 7, 1, 1'b1, 1'b1, 1'b1, 1);
        push(1, 9'h07F, 1'b0, 1'b0, 1'b0);
        send_frame(9'h07F, 7, 1, 1'b1, 1'b1, 1'b1, 1);
        drive_bit(1'b1);

        // 8N2: second stop low gives a framing error, then a clean word
        sel = 2;
        wait_cycles(2);
        push(2, 9'h03C, 1'b0, 1'b1, 1'b0);
        send_frame(9'h03C, 8, 0, 1'b0, 1'b1, 1'b0, 2);
        drive_bit(1'b1);
        push(2, 9'h03C, 1'b0, 1'b0, 1'b0);
        send_frame(9'h03C, 8, 0, 1'b0, 1'b1, 1'b1, 2);
        drive_bit(1'b1);

        // Line break for 12 bit times, then a clean word
        sel = 0;
        wait_cycles(2);
        push(0, 9'h000, 1'b0, 1'b1, 1'b1);
        line = 1'b0;
        wait_cycles(12 * CPB);
        cmp("break_wait_tap", int'(tap_a), 1);
        line = 1'b1;
        wait_cycles(2 * CPB);
        cmp("break_release_tap", int'(tap_a), 0);
        push(0, 9'h055, 1'b0, 1'b0, 1'b0);
        send_frame(9'h055, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive_bit(1'b1);

        // Reset in the middle of data bit 4 aborts the frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        line = 1'b0;
        wait_cycles(3);
        cmp("midframe_tap", int'(tap_a), 1);
        reset_n = 1'b0;
        #1;
        cmp("abort_data", int'(data_a), 0);
        cmp("abort_valid", int'(valid_a), 0);
        cmp("abort_tap", int'(tap_a), 0);
        line = 1'b1;
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(2 * CPB);
        push(0, 9'h081, 1'b0, 1'b0, 1'b0);
        send_frame(9'h081, 8, 0, 1'b0, 1'b1, 1'b1, 1);
        drive_bit(1'b1);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle high glitch at the centre of a 0 data bit
        push(0, 9'h000, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                line = 1'b0;
                wait_cycles(3);
                line = 1'b1;
                wait_cycles(1);
                line = 1'b0;
                wait_cycles(2);
            end else begin
                drive_bit(1'b0);
            end
        end
        drive_bit(1'b1);
`endif

        wait_cycles(4 * CPB);
        cmp("pending_a", q_a.size(), 0);
        cmp("pending_p", q_p.size(), 0);
        cmp("pending_s", q_s.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
